// File: rtl/sisc_ctrl_if.sv
// Bundle between the SISC control FSM and the rest of the processor.
//   master: the control FSM. It samples opcode/mm/stat/mem_ack and drives the datapath controls.
//   slave : the datapath, memory and IR/SR side.
// Signals:
//   opcode [OPW], mm [MMW], stat [STW], mem_ack            : into the FSM
//   ir_load, pc_write, pc_sel, br_sel, rf_we, alu_op [ALUW],
//   rd_sel, wb_sel, mem_req, mem_we, halted, fault         : out of the FSM
//   instr_cnt [32], stall_cnt [32]                         : only with SISC_CTRL_PERFCNT_EN
// Optional feature macro: SISC_CTRL_PERFCNT_EN
interface sisc_ctrl_if #(
    parameter int unsigned OPW  = 4,
    parameter int unsigned MMW  = 4,
    parameter int unsigned STW  = 4,
    parameter int unsigned ALUW = 2
);
    logic [OPW-1:0]  opcode;
    logic [MMW-1:0]  mm;
    logic [STW-1:0]  stat;
    logic            mem_ack;

    logic            ir_load;
    logic            pc_write;
    logic            pc_sel;
    logic            br_sel;
    logic            rf_we;
    logic [ALUW-1:0] alu_op;
    logic            rd_sel;
    logic            wb_sel;
    logic            mem_req;
    logic            mem_we;
    logic            halted;
    logic            fault;
`ifdef SISC_CTRL_PERFCNT_EN
    logic [31:0]     instr_cnt;
    logic [31:0]     stall_cnt;
`endif

    modport master (
        input  opcode, mm, stat, mem_ack,
        output ir_load, pc_write, pc_sel, br_sel, rf_we, alu_op,
               rd_sel, wb_sel, mem_req, mem_we, halted, fault
`ifdef SISC_CTRL_PERFCNT_EN
        , output instr_cnt, stall_cnt
`endif
    );

    modport slave (
        output opcode, mm, stat, mem_ack,
        input  ir_load, pc_write, pc_sel, br_sel, rf_we, alu_op,
               rd_sel, wb_sel, mem_req, mem_we, halted, fault
`ifdef SISC_CTRL_PERFCNT_EN
        , input instr_cnt, stall_cnt
`endif
    );
endinterface

// File: rtl/sisc_ctrl_fsm.sv
// Multi-cycle control FSM for the SISC processor.
// Sequences START0 -> START1 -> FETCH -> DECODE -> EXECUTE -> MEM -> WRITEBACK -> FETCH, with an
// absorbing HALT reached by the HLT opcode or by a memory handshake timeout (sticky fault).
// Ports:
//   clk   : clock, rising edge
//   rst_f : asynchronous active-low reset
//   bus   : sisc_ctrl_if.master (opcode/mm/stat/mem_ack in, datapath controls out)
// Optional feature macro: SISC_CTRL_PERFCNT_EN adds instr_cnt/stall_cnt performance counters.
// STW must equal MMW: the branch mask mm is ANDed bitwise with stat.
module sisc_ctrl_fsm #(
    parameter int unsigned OPW    = 4,
    parameter int unsigned MMW    = 4,
    parameter int unsigned STW    = 4,
    parameter int unsigned ALUW   = 2,
    parameter int unsigned MEM_TO = 16
) (
    input logic       clk,
    input logic       rst_f,
    sisc_ctrl_if.master bus
);

    localparam logic [OPW-1:0] OP_LOD = OPW'(1);
    localparam logic [OPW-1:0] OP_STR = OPW'(2);
    localparam logic [OPW-1:0] OP_BRA = OPW'(4);
    localparam logic [OPW-1:0] OP_BRR = OPW'(5);
    localparam logic [OPW-1:0] OP_BNE = OPW'(6);
    localparam logic [OPW-1:0] OP_ALU = OPW'(8);
    localparam logic [OPW-1:0] OP_HLT = {OPW{1'b1}};

    localparam logic [ALUW-1:0] ALU_RR   = ALUW'(0);
    localparam logic [ALUW-1:0] ALU_RI   = ALUW'(1);
    localparam logic [ALUW-1:0] ALU_ADDR = ALUW'(2);
    localparam logic [ALUW-1:0] ALU_PASS = ALUW'(3);

    localparam int unsigned     CW     = $clog2(MEM_TO + 1);
    localparam logic [CW-1:0]   CNT_TO = CW'(MEM_TO);

    typedef enum logic [2:0] {
        StStart0,
        StStart1,
        StFetch,
        StDecode,
        StExecute,
        StMem,
        StWriteback,
        StHalt
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            fault_q, fault_d;

    logic            ir_load, pc_write, pc_sel, br_sel, rf_we, rd_sel, wb_sel;
    logic            mem_req, mem_we, halted;
    logic [ALUW-1:0] alu_op;

    // Opcode decode; anything not listed falls through as NOOP.
    logic is_lod, is_str, is_mem, is_alu, is_bra, is_brr, is_bne, is_hlt;
    logic imm, br_hit, br_taken;
    logic [STW-1:0] br_hits;

    assign is_lod  = (bus.opcode == OP_LOD);
    assign is_str  = (bus.opcode == OP_STR);
    assign is_mem  = is_lod | is_str;
    assign is_alu  = (bus.opcode == OP_ALU);
    assign is_bra  = (bus.opcode == OP_BRA);
    assign is_brr  = (bus.opcode == OP_BRR);
    assign is_bne  = (bus.opcode == OP_BNE);
    assign is_hlt  = (bus.opcode == OP_HLT);
    assign imm     = bus.mm[MMW-1];
    assign br_hits = bus.stat & bus.mm;
    assign br_hit  = |br_hits;
    assign br_taken = ((is_bra | is_brr) & br_hit) | (is_bne & ~br_hit);

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q <= StStart0;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fault_d  = fault_q;
        ir_load  = 1'b0;
        pc_write = 1'b0;
        pc_sel   = 1'b0;
        br_sel   = 1'b0;
        rf_we    = 1'b0;
        alu_op   = ALU_RR;
        rd_sel   = 1'b0;
        wb_sel   = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        halted   = 1'b0;

        unique case (state_q)
            StStart0: state_d = StStart1;
            StStart1: state_d = StFetch;
            StFetch: begin
                ir_load  = 1'b1;
                pc_write = 1'b1;
                state_d  = StDecode;
            end
            StDecode: state_d = is_hlt ? StHalt : StExecute;
            StExecute: begin
                if (is_alu) begin
                    alu_op = imm ? ALU_RI : ALU_RR;
                    rd_sel = imm;
                end else if (is_mem) begin
                    alu_op = ALU_ADDR;
                end else begin
                    alu_op = ALU_PASS;
                end
                if (br_taken) begin
                    pc_write = 1'b1;
                    pc_sel   = 1'b1;
                    br_sel   = ~is_bra;
                end
                cnt_d   = '0;
                state_d = StMem;
            end
            StMem: begin
                if (is_mem) begin
                    mem_req = 1'b1;
                    mem_we  = is_str;
                    if (bus.mem_ack) begin
                        // An ack on the limit cycle still completes normally.
                        state_d = StWriteback;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_d == CNT_TO) begin
                            state_d = StHalt;
                            fault_d = 1'b1;
                        end
                    end
                end else begin
                    state_d = StWriteback;
                end
            end
            StWriteback: begin
                rf_we   = is_alu | is_lod;
                wb_sel  = is_lod;
                state_d = StFetch;
            end
            StHalt: halted = 1'b1;
            default: state_d = StStart0;
        endcase
    end

    assign bus.ir_load  = ir_load;
    assign bus.pc_write = pc_write;
    assign bus.pc_sel   = pc_sel;
    assign bus.br_sel   = br_sel;
    assign bus.rf_we    = rf_we;
    assign bus.alu_op   = alu_op;
    assign bus.rd_sel   = rd_sel;
    assign bus.wb_sel   = wb_sel;
    assign bus.mem_req  = mem_req;
    assign bus.mem_we   = mem_we;
    assign bus.halted   = halted;
    assign bus.fault    = fault_q;

`ifdef SISC_CTRL_PERFCNT_EN
    logic [31:0] instr_cnt_q, stall_cnt_q;

    // Neither condition can hold in HALT, so both counters freeze there.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            instr_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (state_q == StWriteback) instr_cnt_q <= instr_cnt_q + 32'd1;
            if (mem_req && !bus.mem_ack) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign bus.instr_cnt = instr_cnt_q;
    assign bus.stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_sisc_ctrl_fsm.sv
// Bench for sisc_ctrl_fsm. Each instruction is expanded into its expected per-cycle control
// outputs from the instruction-level rules; a negedge process compares the DUT against them.
module tb_sisc_ctrl_fsm;
    localparam int unsigned OPW    = 4;
    localparam int unsigned MMW    = 4;
    localparam int unsigned STW    = 4;
    localparam int unsigned ALUW   = 2;
    localparam int unsigned MEM_TO = 16;

    logic clk = 1'b0;
    logic rst_f = 1'b0;
    always #5 clk = ~clk;

    sisc_ctrl_if #(.OPW(OPW), .MMW(MMW), .STW(STW), .ALUW(ALUW)) bus ();

    sisc_ctrl_fsm #(.OPW(OPW), .MMW(MMW), .STW(STW), .ALUW(ALUW), .MEM_TO(MEM_TO)) dut (
        .clk   (clk),
        .rst_f (rst_f),
        .bus   (bus)
    );

    typedef struct {
        string      tag;
        logic       ack;   // stimulus for this cycle
        logic       wb;    // cycle retires an instruction
        logic       clr;   // reset is low this cycle
        logic       ir_load, pc_write, pc_sel, br_sel, rf_we;
        logic [1:0] alu_op;
        logic       rd_sel, wb_sel, mem_req, mem_we, halted, fault;
    } rec_t;

    rec_t exp_q[$];
    rec_t drv_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic rec_t blank(input string tag);
        rec_t r;
        r.tag = tag; r.ack = 1'b0; r.wb = 1'b0; r.clr = 1'b0;
        r.ir_load = 1'b0; r.pc_write = 1'b0; r.pc_sel = 1'b0; r.br_sel = 1'b0; r.rf_we = 1'b0;
        r.alu_op = 2'b00; r.rd_sel = 1'b0; r.wb_sel = 1'b0; r.mem_req = 1'b0; r.mem_we = 1'b0;
        r.halted = 1'b0; r.fault = 1'b0;
        return r;
    endfunction

    function automatic logic [12:0] pack(input rec_t r);
        return {r.ir_load, r.pc_write, r.pc_sel, r.br_sel, r.rf_we, r.alu_op,
                r.rd_sel, r.wb_sel, r.mem_req, r.mem_we, r.halted, r.fault};
    endfunction

    function automatic logic [12:0] dut_ctl();
        return {bus.ir_load, bus.pc_write, bus.pc_sel, bus.br_sel, bus.rf_we, bus.alu_op,
                bus.rd_sel, bus.wb_sel, bus.mem_req, bus.mem_we, bus.halted, bus.fault};
    endfunction

    task automatic push(input rec_t r);
        exp_q.push_back(r);
        drv_q.push_back(r);
    endtask

    // Expand one instruction into its cycles. ack_cycle: MEM cycle (1-based) carrying mem_ack,
    // 0 = never. hold: cycles of HALT to observe if the instruction halts.
    task automatic build(input logic [3:0] op, input logic [3:0] mm, input logic [3:0] stat,
                         input int ack_cycle, input int hold);
        rec_t r;
        logic hit, taken;
        int   n;
        r = blank("fetch"); r.ir_load = 1'b1; r.pc_write = 1'b1; push(r);
        push(blank("decode"));
        if (op == 4'hF) begin
            for (int i = 0; i < hold; i++) begin
                r = blank("hlt_halt"); r.halted = 1'b1; push(r);
            end
            return;
        end
        r = blank("execute");
        if (op == 4'd8) begin
            r.alu_op = mm[3] ? 2'b01 : 2'b00;
            r.rd_sel = mm[3];
        end else if (op == 4'd1 || op == 4'd2) begin
            r.alu_op = 2'b10;
        end else begin
            r.alu_op = 2'b11;
        end
        hit = ((mm & stat) != 4'd0);
        if (op == 4'd4 || op == 4'd5) taken = hit;
        else if (op == 4'd6)          taken = !hit;
        else                          taken = 1'b0;
        if (taken) begin
            r.pc_write = 1'b1; r.pc_sel = 1'b1; r.br_sel = (op != 4'd4);
        end
        push(r);
        if (op == 4'd1 || op == 4'd2) begin
            n = (ack_cycle >= 1 && ack_cycle <= int'(MEM_TO)) ? ack_cycle : int'(MEM_TO);
            for (int i = 1; i <= n; i++) begin
                r = blank("mem");
                r.mem_req = 1'b1; r.mem_we = (op == 4'd2); r.ack = (i == ack_cycle);
                push(r);
            end
            if (!(ack_cycle >= 1 && ack_cycle <= int'(MEM_TO))) begin
                for (int i = 0; i < hold; i++) begin
                    r = blank("timeout_halt"); r.halted = 1'b1; r.fault = 1'b1; push(r);
                end
                return;
            end
        end else begin
            r = blank("mem_nomem"); r.ack = 1'b1; push(r);  // ack must be ignored
        end
        r = blank("writeback");
        r.rf_we = (op == 4'd8 || op == 4'd1); r.wb_sel = (op == 4'd1); r.wb = 1'b1;
        push(r);
    endtask

    task automatic setin(input logic [3:0] op, input logic [3:0] mm, input logic [3:0] stat);
        bus.opcode = op; bus.mm = mm; bus.stat = stat;
    endtask

    task automatic drive_all();
        rec_t r;
        while (drv_q.size() > 0) begin
            r = drv_q.pop_front();
            bus.mem_ack = r.ack;
            @(posedge clk); #1;
        end
    endtask

    task automatic run(input logic [3:0] op, input logic [3:0] mm, input logic [3:0] stat,
                       input int ack_cycle, input int hold);
        setin(op, mm, stat);
        build(op, mm, stat, ack_cycle, hold);
        drive_all();
    endtask

    task automatic do_reset();
        rec_t r;
        rst_f = 1'b0;
        bus.mem_ack = 1'b0;
        r = blank("reset"); r.clr = 1'b1;
        exp_q.push_back(r);
        @(posedge clk); #1;
        exp_q.push_back(r);
        rst_f = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back(blank("start1"));
        @(posedge clk); #1;
    endtask

`ifdef SISC_CTRL_PERFCNT_EN
    int unsigned m_instr = 0;
    int unsigned m_stall = 0;
`endif

    always @(negedge clk) begin : compare
        rec_t r;
        if (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            check({"ctl_", r.tag}, 32'(dut_ctl()), 32'(pack(r)));
`ifdef SISC_CTRL_PERFCNT_EN
            if (r.clr) begin
                m_instr = 0;
                m_stall = 0;
            end
            check({"instr_cnt_", r.tag}, bus.instr_cnt, m_instr);
            check({"stall_cnt_", r.tag}, bus.stall_cnt, m_stall);
            if (r.wb) m_instr++;
            if (r.mem_req && !r.ack) m_stall++;
`endif
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int n;
        bus.opcode = '0; bus.mm = '0; bus.stat = '0; bus.mem_ack = 1'b0;
        @(posedge clk); #1;
        do_reset();

        // ALU immediate: exactly 5 cycles, pinned by hand.
        setin(4'd8, 4'b1000, 4'b0000);
        build(4'd8, 4'b1000, 4'b0000, 0, 0);
        check("pin_alu_imm_cycles", exp_q.size(), 5);
        check("pin_alu_imm_exec", {exp_q[2].alu_op, exp_q[2].rd_sel}, 3'b011);
        check("pin_alu_imm_wb", {exp_q[4].rf_we, exp_q[4].wb_sel}, 2'b10);
        drive_all();

        run(4'd8, 4'b0011, 4'b1111, 0, 0);

        // LOD with ack in third MEM cycle.
        setin(4'd1, 4'b0000, 4'b0000);
        build(4'd1, 4'b0000, 4'b0000, 3, 0);
        check("pin_lod_cycles", exp_q.size(), 7);
        check("pin_lod_wb", {exp_q[6].rf_we, exp_q[6].wb_sel}, 2'b11);
        drive_all();

        run(4'd2, 4'b0000, 4'b0000, 1, 0);                // STR, immediate ack

        // Branches.
        setin(4'd5, 4'b0010, 4'b0010);
        build(4'd5, 4'b0010, 4'b0010, 0, 0);
        check("pin_brr_taken", {exp_q[2].pc_write, exp_q[2].pc_sel, exp_q[2].br_sel}, 3'b111);
        drive_all();
        setin(4'd6, 4'b0010, 4'b0010);
        build(4'd6, 4'b0010, 4'b0010, 0, 0);
        check("pin_bne_not_taken", exp_q[2].pc_write, 1'b0);
        drive_all();
        run(4'd4, 4'b0001, 4'b0001, 0, 0);                // BRA taken, absolute
        run(4'd4, 4'b1000, 4'b0111, 0, 0);                // BRA not taken
        run(4'd6, 4'b0010, 4'b0100, 0, 0);                // BNE taken

        run(4'd0, 4'b1111, 4'b1111, 0, 0);                // NOOP
        run(4'd3, 4'b1010, 4'b1010, 0, 0);                // unknown -> NOOP
        run(4'd12, 4'b1000, 4'b1000, 0, 0);               // unknown -> NOOP

        run(4'd2, 4'b0000, 4'b0000, int'(MEM_TO), 0);     // ack on the limit cycle wins

        // Reset in the middle of a LOD handshake.
        setin(4'd1, 4'b0000, 4'b0000);
        build(4'd1, 4'b0000, 4'b0000, 0, 0);
        while (exp_q.size() > 4) void'(exp_q.pop_back());
        while (drv_q.size() > 4) void'(drv_q.pop_back());
        drive_all();
        check("midmem_req_before_reset", bus.mem_req, 1'b1);
        #2 rst_f = 1'b0;
        #1 check("midmem_outputs_after_reset", 32'(dut_ctl()), 32'd0);
        do_reset();

        // STR timeout.
        setin(4'd2, 4'b0000, 4'b0000);
        build(4'd2, 4'b0000, 4'b0000, 0, 6);
        n = 0;
        foreach (exp_q[i]) if (exp_q[i].mem_req) n++;
        check("pin_timeout_mem_cycles", n, 16);
        drive_all();
        do_reset();

        // HLT: halts after DECODE and stays quiet.
        setin(4'hF, 4'b0000, 4'b0000);
        build(4'hF, 4'b0000, 4'b0000, 0, 20);
        check("pin_hlt_cycles", exp_q.size(), 22);
        drive_all();
        do_reset();

        run(4'd8, 4'b0101, 4'b0000, 0, 0);                // recovery after reset

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
